// File: rtl/logic_gate_unit_pkg.sv
// Shared definitions for the logic gate unit: op encodings, base-op
// classification helpers and FSM state codes.
package logic_gate_unit_pkg;

    // Operation encodings presented on in_op
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    // FSM state codes, kept as plain constants for compatibility with older cells
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    // Base operator used while folding; inversion is applied only at emission
    typedef enum logic [1:0] {
        BASE_AND = 2'd0,
        BASE_OR  = 2'd1,
        BASE_XOR = 2'd2
    } base_op_e;

    // Codes 6 and 7 have no meaning and fall back to AND
    function automatic logic op_is_illegal(input logic [2:0] op);
        return (op > OP_XNOR);
    endfunction

    // Inverting ops fold with their base op and complement the final result once
    function automatic logic op_is_inv(input logic [2:0] op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    // Map any op code (legal or not) onto the operator used for folding
    function automatic base_op_e op_base(input logic [2:0] op);
        case (op)
            OP_AND, OP_NAND: return BASE_AND;
            OP_OR, OP_NOR:   return BASE_OR;
            OP_XOR, OP_XNOR: return BASE_XOR;
            default:         return BASE_AND;
        endcase
    endfunction

endpackage

// File: rtl/logic_reduce.sv
// Combinational reduction of NUM_IN operands of WIDTH bits each using a
// non-inverting base operator (AND/OR/XOR).
module logic_reduce
    import logic_gate_unit_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
) (
    input  base_op_e                  base_op,
    input  logic [NUM_IN*WIDTH-1:0]   data,
    output logic [WIDTH-1:0]          result
);

    // Fold operand 0 with every following operand under the selected base op
    always_comb begin
        result = data[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            case (base_op)
                BASE_OR:  result = result | data[k*WIDTH +: WIDTH];
                BASE_XOR: result = result ^ data[k*WIDTH +: WIDTH];
                default:  result = result & data[k*WIDTH +: WIDTH];
            endcase
        end
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered bitwise logic unit. Reduces NUM_IN operands per beat with a
// selectable op and can fold a whole burst of beats into one result.
// Valid/ready handshakes on both sides; the output register holds while
// the consumer stalls.
module logic_gate_unit
    import logic_gate_unit_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  NUM_IN    = 2,
    parameter int  MAX_BEATS = 16,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_IN*WIDTH-1:0]  in_data,
    input  logic [2:0]               in_op,
    input  logic                     in_acc,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [CNT_W-1:0]         out_count,
    output logic                     out_err
);

    logic [0:0]       state_q;
    logic [WIDTH-1:0] acc_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic             beat_fire;
    logic             in_burst;
    logic [2:0]       eff_op;
    base_op_e         eff_base;
    logic [WIDTH-1:0] beat_red;
    logic [WIDTH-1:0] fold;
    logic [WIDTH-1:0] final_data;
    logic [CNT_W-1:0] cnt_next;
    logic             err_next;
    logic             emit;
    logic             start_burst;

    assign in_ready  = !out_valid || out_ready;
    assign beat_fire = in_valid && in_ready;
    assign in_burst  = (state_q == ST_ACCUM);

    // During a burst the op latched on the first beat governs every fold
    assign eff_op   = in_burst ? op_q : in_op;
    assign eff_base = op_base(eff_op);

    logic_reduce #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_reduce (
        .base_op (eff_base),
        .data    (in_data),
        .result  (beat_red)
    );

    // Combine the current beat with the running accumulator and work out the
    // next count, error and whether this beat completes a result
    always_comb begin
        fold        = beat_red;
        cnt_next    = CNT_W'(1);
        err_next    = op_is_illegal(in_op);
        start_burst = 1'b0;
        emit        = 1'b0;
        if (in_burst) begin
            case (eff_base)
                BASE_OR:  fold = acc_q | beat_red;
                BASE_XOR: fold = acc_q ^ beat_red;
                default:  fold = acc_q & beat_red;
            endcase
            if (cnt_q == CNT_W'(MAX_BEATS)) begin
                cnt_next = cnt_q;
                err_next = 1'b1;
            end else begin
                cnt_next = cnt_q + CNT_W'(1);
                err_next = err_q || (in_op != op_q);
            end
            emit = beat_fire && in_last;
        end else begin
            start_burst = beat_fire && in_acc && !in_last;
            emit        = beat_fire && !(in_acc && !in_last);
        end
        final_data = op_is_inv(eff_op) ? ~fold : fold;
    end

    // Burst state: FSM, accumulator, latched op, beat counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (beat_fire) begin
            if (in_burst) begin
                acc_q <= fold;
                cnt_q <= cnt_next;
                err_q <= err_next;
                if (in_last) begin
                    state_q <= ST_IDLE;
                end
            end else if (start_burst) begin
                acc_q   <= beat_red;
                op_q    <= in_op;
                cnt_q   <= CNT_W'(1);
                err_q   <= op_is_illegal(in_op);
                state_q <= ST_ACCUM;
            end
        end
    end

    // Output register: load on a completing beat, clear valid once consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_data  <= final_data;
            out_count <= cnt_next;
            out_err   <= err_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
